// File: rtl/prng_pkg.sv
// Shared definitions for the rolling random-number display: FSM states,
// active-low 7-segment codes ({g,f,e,d,c,b,a}) and the default roll interval.
package prng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int BASE_DIV_DEFAULT = 1_562_500;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/seg7_encode.sv
// Combinational nibble to active-low 7-segment decoder; hex digits 0-F.
module seg7_encode
    import prng_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_0;
        case (nib_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            default: seg_o = SEG_F;
        endcase
    end

endmodule

// File: rtl/prng_roll_display.sv
// Dice-style roll: shows ROLL_STEPS random bytes with linearly growing intervals,
// then settles. Define PRNG_ROLL_BCD_MODE_EN to show the byte mod 100 in decimal.
module prng_roll_display
    import prng_pkg::*;
#(
    parameter int BASE_DIV   = BASE_DIV_DEFAULT,
    parameter int ROLL_STEPS = 6
)(
    input  logic       CLK,
    input  logic       rst,
    input  logic [7:0] rnd_data,
    input  logic       rnd_valid,
    output logic       rnd_ready,
    input  logic       roll_req,
    output logic       busy,
    output logic       done,
    output logic [7:0] value,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1
);

    localparam int CNT_W = $clog2(BASE_DIV * ROLL_STEPS + 1);
    localparam logic [CNT_W-1:0] BASE_C    = CNT_W'(BASE_DIV);
    localparam logic [3:0]       LAST_STEP = 4'(ROLL_STEPS - 1);

    state_e           state_q, state_d;
    logic [3:0]       step_q, step_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] tgt_q, tgt_d;
    logic [7:0]       disp_q, disp_d;
    logic [7:0]       value_q, value_d;
    logic             req_prev_q;
    logic [6:0]       hex0_q, hex1_q;
    logic [3:0]       nib_lo, nib_hi;
    logic [6:0]       seg_lo, seg_hi;

    // tgt_q accumulates BASE_DIV per step, so the WAIT length is BASE_DIV*(step+1)
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        disp_d  = disp_q;
        value_d = value_q;
        case (state_q)
            ST_IDLE: begin
                if (roll_req && !req_prev_q) begin
                    state_d = ST_FETCH;
                    step_d  = '0;
                    cnt_d   = '0;
                    tgt_d   = BASE_C;
                end
            end
            ST_FETCH: begin
                if (rnd_valid) begin
                    disp_d  = rnd_data;
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == tgt_q - CNT_W'(1)) begin
                    if (step_q == LAST_STEP) begin
                        state_d = ST_DONE;
                    end else begin
                        step_d  = step_q + 4'd1;
                        tgt_d   = tgt_q + BASE_C;
                        state_d = ST_FETCH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                value_d = disp_q;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            cnt_q      <= '0;
            tgt_q      <= '0;
            disp_q     <= '0;
            value_q    <= '0;
            req_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            cnt_q      <= cnt_d;
            tgt_q      <= tgt_d;
            disp_q     <= disp_d;
            value_q    <= value_d;
            req_prev_q <= roll_req;
        end
    end

`ifdef PRNG_ROLL_BCD_MODE_EN
    logic [7:0] mod100;
    always_comb begin
        mod100 = disp_q % 8'd100;
        nib_hi = 4'(mod100 / 8'd10);
        nib_lo = 4'(mod100 % 8'd10);
    end
`else
    always_comb begin
        nib_lo = disp_q[3:0];
        nib_hi = disp_q[7:4];
    end
`endif

    seg7_encode u_seg_lo (.nib_i(nib_lo), .seg_o(seg_lo));
    seg7_encode u_seg_hi (.nib_i(nib_hi), .seg_o(seg_hi));

    always_ff @(posedge CLK) begin
        if (rst) begin
            hex0_q <= SEG_0;
            hex1_q <= SEG_0;
        end else begin
            hex0_q <= seg_lo;
            hex1_q <= seg_hi;
        end
    end

    assign rnd_ready = (state_q == ST_FETCH);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign value     = value_q;
    assign HEX0      = hex0_q;
    assign HEX1      = hex1_q;

endmodule
